// File: rtl/demux1t4_5_buf_pkg.sv
// Shared types for the double-buffered 1:4 display-code demultiplexer.
package demux1t4_5_buf_pkg;

  localparam int unsigned CODE_W = 5;
  localparam int unsigned SLOTS  = 4;

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic {
    FILL   = 1'b0,
    COMMIT = 1'b1
  } state_t;

endpackage

// File: rtl/demux1t4_5_buf_slot_ptr2.sv
// 2-bit wrapping slot pointer; clr has priority over inc.
module slot_ptr2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/demux1t4_5_buf.sv
// Collects four codes into a shadow bank and commits them atomically to o0..o3.
module demux1t4_5_buf
  import demux1t4_5_buf_pkg::*;
#(
  parameter int unsigned W       = 5,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         addr_mode,
  input  logic [1:0]   din_slot,
  input  logic         frame_clr,
  output logic [W-1:0] o0,
  output logic [W-1:0] o1,
  output logic [W-1:0] o2,
  output logic [W-1:0] o3,
  output logic [1:0]   slot_cnt,
  output logic         frame_done
);

  state_t       state, state_nxt;
  logic [W-1:0] shadow [SLOTS];
  logic [SLOTS-1:0] mask, mask_upd;
  logic [1:0]   slot;
  logic         accept;
  logic         in_commit;
  logic         ptr_inc, ptr_clr;

  assign din_ready = (state == FILL);
  assign in_commit = (state == COMMIT);
  assign accept    = din_valid && din_ready && !frame_clr;
  assign slot      = addr_mode ? din_slot : slot_cnt;

  always_comb begin
    mask_upd = mask;
    if (accept) begin
      mask_upd[slot] = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL:    if (accept && (mask_upd == '1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // frame_clr only acts in FILL; during COMMIT the commit path clears mask anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
    end else if (in_commit || frame_clr) begin
      mask <= '0;
    end else begin
      mask <= mask_upd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        shadow[i] <= RST_VAL;
      end
    end else if (accept) begin
      shadow[slot] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o0         <= RST_VAL;
      o1         <= RST_VAL;
      o2         <= RST_VAL;
      o3         <= RST_VAL;
      frame_done <= 1'b0;
    end else begin
      frame_done <= in_commit;
      if (in_commit) begin
        o0 <= shadow[0];
        o1 <= shadow[1];
        o2 <= shadow[2];
        o3 <= shadow[3];
      end
    end
  end

  assign ptr_inc = accept && !addr_mode;
  assign ptr_clr = in_commit || frame_clr;

  slot_ptr2 u_slot_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ptr_inc),
    .clr   (ptr_clr),
    .cnt   (slot_cnt)
  );

endmodule
